fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_skid_buf.sv | 34 +++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared pipeline definitions for the instruction fetch stage: FSM encoding,
// instruction width and the NOP word.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register holding an instruction and its PC+4 while the
// output slot is blocked; clear wins over push, push wins over pop.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               push,
    input  logic               pop,
    input  logic [INSTR_W-1:0] din_instr,
    input  logic [31:0]        din_pc,
    output logic               full,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            instr <= NOP;
            pc    <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (push) begin
            full  <= 1'b1;
            instr <= din_instr;
            pc    <= din_pc;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, FETCH/HOLD/DROP sequencer and the
// IF/ID output slot. Define FETCH_SKID_EN to add a one-entry skid buffer.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               Stall,
    input  logic               Redirect,
    input  logic [31:0]        Redirect_PC,
    output logic               IMem_Req,
    output logic [31:0]        IMem_Addr,
    input  logic               IMem_Ack,
    input  logic [INSTR_W-1:0] IMem_Data,
    output logic [INSTR_W-1:0] Instruction_Out,
    output logic [31:0]        PC_Out,
    output logic               Valid_Out,
    output logic [1:0]         fsm_state
);

    // Handshake: IMem_Req/IMem_Addr stay constant from assertion until the
    // edge where IMem_Ack=1; the slot is consumed at an edge with
    // Valid_Out=1, Stall=0, Redirect=0.

`ifdef FETCH_SKID_EN
    localparam bit SKID_EN = 1'b1;
`else
    localparam bit SKID_EN = 1'b0;
`endif

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  drop_addr_q;
    logic [31:0]  pc_next;
    logic [31:0]  redirect_aligned;
    logic         consume;

    logic               skid_full;
    logic [INSTR_W-1:0] skid_instr;
    logic [31:0]        skid_pc;

    assign pc_next          = pc_q + 32'd4;
    assign redirect_aligned = Redirect_PC & 32'hFFFF_FFFC;
    assign consume          = Valid_Out && !Stall && !Redirect;

    // DROP keeps presenting the abandoned address until its response returns.
    assign IMem_Req  = Reset_n && (state_q != ST_HOLD);
    assign IMem_Addr = (state_q == ST_DROP) ? drop_addr_q : pc_q;
    assign fsm_state = state_q;

`ifdef FETCH_SKID_EN
    logic skid_push;
    logic skid_pop;

    assign skid_push = (state_q == ST_FETCH) && IMem_Ack && Valid_Out && Stall && !Redirect;
    assign skid_pop  = (state_q == ST_HOLD) && consume;

    fetch_skid_buf u_skid (
        .clk       (Clock),
        .rst_n     (Reset_n),
        .clear     (Redirect),
        .push      (skid_push),
        .pop       (skid_pop),
        .din_instr (IMem_Data),
        .din_pc    (pc_next),
        .full      (skid_full),
        .instr     (skid_instr),
        .pc        (skid_pc)
    );
`else
    assign skid_full  = 1'b0;
    assign skid_instr = NOP;
    assign skid_pc    = '0;
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q         <= ST_FETCH;
            pc_q            <= RESET_PC;
            drop_addr_q     <= '0;
            Valid_Out       <= 1'b0;
            Instruction_Out <= NOP;
            PC_Out          <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (Redirect) begin
                        pc_q      <= redirect_aligned;
                        Valid_Out <= 1'b0;
                        if (!IMem_Ack) begin
                            state_q     <= ST_DROP;
                            drop_addr_q <= pc_q;
                        end
                    end else if (IMem_Ack && (!Valid_Out || consume)) begin
                        Instruction_Out <= IMem_Data;
                        PC_Out          <= pc_next;
                        Valid_Out       <= 1'b1;
                        pc_q            <= pc_next;
                    end else if (IMem_Ack) begin
                        // Slot blocked: the skid takes this word, otherwise it
                        // is refetched from the same PC after the stall.
                        if (SKID_EN) pc_q <= pc_next;
                        state_q <= ST_HOLD;
                    end else if (consume) begin
                        Valid_Out <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (Redirect) begin
                        pc_q      <= redirect_aligned;
                        Valid_Out <= 1'b0;
                        state_q   <= ST_FETCH;
                    end else if (consume) begin
                        state_q <= ST_FETCH;
                        if (skid_full) begin
                            Instruction_Out <= skid_instr;
                            PC_Out          <= skid_pc;
                        end else begin
                            Valid_Out <= 1'b0;
                        end
                    end
                end
                ST_DROP: begin
                    if (Redirect) pc_q <= redirect_aligned;
                    if (IMem_Ack) state_q <= ST_FETCH;
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the fetch stage.
module tb_fetch_unit;

`ifdef FETCH_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    localparam bit SKID = (CAP > 1);

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_ack;
    logic [31:0] imem_data;

    logic        req,    hi_req;
    logic [31:0] addr,   hi_addr;
    logic [31:0] instr,  hi_instr;
    logic [31:0] pc_out, hi_pc_out;
    logic        valid,  hi_valid;
    logic [1:0]  state,  hi_state;

    fetch_unit u_dut (
        .Clock(clk), .Reset_n(rst_n), .Stall(stall), .Redirect(redirect),
        .Redirect_PC(redirect_pc), .IMem_Req(req), .IMem_Addr(addr),
        .IMem_Ack(imem_ack), .IMem_Data(imem_data), .Instruction_Out(instr),
        .PC_Out(pc_out), .Valid_Out(valid), .fsm_state(state)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_hi (
        .Clock(clk), .Reset_n(rst_n), .Stall(stall), .Redirect(redirect),
        .Redirect_PC(redirect_pc), .IMem_Req(hi_req), .IMem_Addr(hi_addr),
        .IMem_Ack(imem_ack), .IMem_Data(imem_data), .Instruction_Out(hi_instr),
        .PC_Out(hi_pc_out), .Valid_Out(hi_valid), .fsm_state(hi_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: buffered instructions {instr, pc+4}, slot first
    logic [63:0] exp_q[$];
    logic [31:0] m_pc, m_drop_addr, m_instr, m_pcout;
    bit          m_blocked, m_drop;

    task automatic model_reset(input logic [31:0] rpc);
        exp_q.delete();
        m_pc = rpc; m_drop_addr = '0; m_instr = '0; m_pcout = '0;
        m_blocked = 0; m_drop = 0;
    endtask

    task automatic model_edge();
        bit m_req, take;
        m_req = !m_blocked;
        take  = (exp_q.size() > 0) && !stall && !redirect;
        if (redirect) begin
            if (m_req && !imem_ack) begin
                if (!m_drop) m_drop_addr = m_pc;
                m_drop = 1;
            end else begin
                m_drop = 0;
            end
            exp_q.delete();
            m_blocked = 0;
            m_pc = {redirect_pc[31:2], 2'b00};
        end else if (m_drop) begin
            if (imem_ack) m_drop = 0;
        end else if (m_blocked) begin
            if (take) begin
                void'(exp_q.pop_front());
                m_blocked = 0;
            end
        end else begin
            if (take) void'(exp_q.pop_front());
            if (imem_ack) begin
                if (exp_q.size() < CAP) begin
                    exp_q.push_back({imem_data, m_pc + 32'd4});
                    m_pc = m_pc + 32'd4;
                    if (exp_q.size() > 1) m_blocked = 1;
                end else begin
                    m_blocked = 1;
                end
            end
        end
        if (exp_q.size() > 0) begin
            m_instr = exp_q[0][63:32];
            m_pcout = exp_q[0][31:0];
        end
    endtask

    task automatic compare_all();
        check("req", {31'd0, req}, {31'd0, !m_blocked});
        if (!m_blocked) check("addr", addr, m_drop ? m_drop_addr : m_pc);
        check("valid", {31'd0, valid}, {31'd0, exp_q.size() > 0});
        check("instr", instr, m_instr);
        check("pc_out", pc_out, m_pcout);
    endtask

    // drivers
    task automatic step(input logic s, input logic r, input logic [31:0] rp, input logic a);
        stall = s; redirect = r; redirect_pc = rp; imem_ack = a;
        imem_data = $urandom();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        model_reset(32'h0);
        stall = 0; redirect = 0; redirect_pc = '0; imem_ack = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare_all();
        check("rst_addr", addr, 32'h0);
        check("hi_rst_addr", hi_addr, 32'hFFFF_FFFC);
    endtask

    initial begin
        rst_n = 1'b0; stall = 0; redirect = 0; redirect_pc = '0;
        imem_ack = 0; imem_data = '0;
        @(negedge clk);
        do_reset();

        // back-to-back fetch from reset; high RESET_PC wraps
        step(0, 0, 0, 1);
        check("seq_addr1", addr, 32'h4);
        check("seq_pc1", pc_out, 32'h4);
        check("hi_addr_wrap", hi_addr, 32'h0);
        check("hi_pc_wrap", hi_pc_out, 32'h0);
        check("hi_valid", {31'd0, hi_valid}, 32'd1);
        step(0, 0, 0, 1);
        check("seq_addr2", addr, 32'h8);
        check("seq_pc2", pc_out, 32'h8);

        // three-cycle stall, then release
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1);
            check("stall_req", {31'd0, req}, 32'd0);
            check("stall_pc", pc_out, 32'h8);
            check("stall_valid", {31'd0, valid}, 32'd1);
        end
        step(0, 0, 0, 1);
        check("rel_pc", pc_out, SKID ? 32'hC : 32'h8);
        check("rel_valid", {31'd0, valid}, {31'd0, SKID});
        step(0, 0, 0, 1);
        check("rel2_pc", pc_out, SKID ? 32'h10 : 32'hC);

        // redirect with response outstanding
        do_reset();
        step(0, 0, 0, 1);
        step(0, 1, 32'h0000_0103, 0);
        check("drop_addr", addr, 32'h4);
        check("drop_valid", {31'd0, valid}, 32'd0);
        step(0, 0, 0, 0);
        check("drop_hold", addr, 32'h4);
        step(0, 0, 0, 1);
        check("drop_new_addr", addr, 32'h100);
        check("drop_valid2", {31'd0, valid}, 32'd0);
        step(0, 0, 0, 1);
        check("drop_pc", pc_out, 32'h104);

        // redirect together with ack: no DROP cycle
        step(0, 1, 32'h40, 1);
        check("redir_ack_addr", addr, 32'h40);
        check("redir_ack_req", {31'd0, req}, 32'd1);
        step(0, 0, 0, 1);
        check("redir_ack_pc", pc_out, 32'h44);

        // second redirect while dropping
        step(0, 1, 32'h300, 0);
        step(0, 1, 32'h500, 0);
        check("drop2_addr", addr, 32'h44);
        step(0, 0, 0, 1);
        check("drop2_new", addr, 32'h500);

        // reset pulsed during DROP
        step(0, 1, 32'h200, 0);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
                     $urandom(), $urandom_range(0, 9) < 6);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
